// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude adder.
package sm_pkg;

  // Default total word width: 1 sign bit plus magnitude bits.
  localparam int unsigned SmWidthDefault = 8;

  // Sign-magnitude word at the default width.
  typedef struct packed {
    logic                      sign;
    logic [SmWidthDefault-2:0] mag;
  } sm_word_t;

endpackage

// File: rtl/signed_adder_if.sv
// Operand/result bundle for signed_adder.
interface signed_adder_if
  import sm_pkg::*;
#(
  parameter int unsigned N = SmWidthDefault
);

  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] S;
  logic         out_valid;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, A, B,
    input  S, out_valid, ovf, zero
  );

  modport slave (
    input  in_valid, A, B,
    output S, out_valid, ovf, zero
  );

endinterface

// File: rtl/sm_mag_addsub.sv
// Combinational sign-magnitude core: unsigned compare, add and subtract of magnitudes.
module sm_mag_addsub
  import sm_pkg::*;
#(
  parameter int unsigned W = SmWidthDefault - 1
) (
  input  logic [W-1:0] mag_a,
  input  logic [W-1:0] mag_b,
  input  logic         sign_a,
  input  logic         sign_b,
  output logic [W-1:0] mag_s,
  output logic         sign_s,
  output logic         ovf
);

  logic         eff_sign_a;
  logic         eff_sign_b;
  logic [W:0]   sum_ext;
  logic         a_ge_b;
  logic [W-1:0] diff;
  logic         raw_sign;

  // Negative-zero operands are treated as +0 by clearing their sign.
  assign eff_sign_a = sign_a & (|mag_a);
  assign eff_sign_b = sign_b & (|mag_b);

  assign sum_ext = {1'b0, mag_a} + {1'b0, mag_b};
  assign a_ge_b  = (mag_a >= mag_b);
  assign diff    = a_ge_b ? (mag_a - mag_b) : (mag_b - mag_a);

  // Select add or subtract by sign agreement; a zero magnitude always gets sign 0.
  always_comb begin
    mag_s    = '0;
    raw_sign = 1'b0;
    ovf      = 1'b0;
    if (eff_sign_a == eff_sign_b) begin
      mag_s    = sum_ext[W-1:0];
      raw_sign = eff_sign_a;
      ovf      = sum_ext[W];
    end else begin
      mag_s    = diff;
      raw_sign = a_ge_b ? eff_sign_a : eff_sign_b;
    end
    sign_s = raw_sign & (|mag_s);
  end

endmodule

// File: rtl/signed_adder.sv
// Registered sign-magnitude adder: one operand pair per cycle, 1-cycle latency.
module signed_adder
  import sm_pkg::*;
#(
  parameter int unsigned N = SmWidthDefault
) (
  input logic          clk,
  input logic          rst_n,
  signed_adder_if.slave bus
);

  logic [N-2:0] mag_res;
  logic         sign_res;
  logic         ovf_res;

  logic [N-1:0] s_q;
  logic         ovf_q;
  logic         zero_q;
  logic         valid_q;

  sm_mag_addsub #(
    .W(N - 1)
  ) u_core (
    .mag_a (bus.A[N-2:0]),
    .mag_b (bus.B[N-2:0]),
    .sign_a(bus.A[N-1]),
    .sign_b(bus.B[N-1]),
    .mag_s (mag_res),
    .sign_s(sign_res),
    .ovf   (ovf_res)
  );

  // Output registers: capture on acceptance, hold otherwise; reset clears immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s_q    <= {sign_res, mag_res};
        ovf_q  <= ovf_res;
        zero_q <= ~(|mag_res);
      end
    end
  end

  assign bus.S         = s_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_signed_adder.sv
// Directed, table-driven bench for signed_adder at N=8.
module tb_signed_adder;
  import sm_pkg::*;

  typedef struct {
    sm_word_t a;
    sm_word_t b;
    sm_word_t s;
    logic     ovf;
    logic     zero;
  } vec_t;

  localparam int NumVec = 13;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [NumVec];

  signed_adder_if #(.N(8)) bus ();

  signed_adder #(
    .N(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input sm_word_t s,
                           input logic o, input logic z);
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({name, ".S"},         32'(bus.S),         32'(s));
    check({name, ".ovf"},       32'(bus.ovf),       32'(o));
    check({name, ".zero"},      32'(bus.zero),      32'(z));
  endtask

  task automatic drive(input logic v, input sm_word_t a, input sm_word_t b);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          A              B              S              ovf   zero
    vecs[0]  = '{8'b1100_0110, 8'b1001_1110, 8'b1110_0100, 1'b0, 1'b0}; // -70 + -30
    vecs[1]  = '{8'b0110_1101, 8'b1100_1011, 8'b0010_0010, 1'b0, 1'b0}; // +109 + -75
    vecs[2]  = '{8'b1011_1000, 8'b0000_1101, 8'b1010_1011, 1'b0, 1'b0}; // -56 + +13
    vecs[3]  = '{8'b0001_0100, 8'b0010_1111, 8'b0100_0011, 1'b0, 1'b0}; // +20 + +47
    vecs[4]  = '{8'b0111_1111, 8'b0000_0001, 8'b0000_0000, 1'b1, 1'b1}; // +127 + +1 wraps
    vecs[5]  = '{8'b0010_1000, 8'b1010_1000, 8'b0000_0000, 1'b0, 1'b1}; // +40 + -40
    vecs[6]  = '{8'b1000_0000, 8'b1000_0000, 8'b0000_0000, 1'b0, 1'b1}; // -0 + -0
    vecs[7]  = '{8'b1100_0000, 8'b1100_0000, 8'b0000_0000, 1'b1, 1'b1}; // -64 + -64 wraps to +0
    vecs[8]  = '{8'b1111_1111, 8'b1111_1111, 8'b1111_1110, 1'b1, 1'b0}; // -127 + -127
    vecs[9]  = '{8'b1000_0000, 8'b0000_0011, 8'b0000_0011, 1'b0, 1'b0}; // -0 + +3
    vecs[10] = '{8'b1000_0000, 8'b1000_0011, 8'b1000_0011, 1'b0, 1'b0}; // -0 + -3
    vecs[11] = '{8'b0000_0011, 8'b1000_0111, 8'b1000_0100, 1'b0, 1'b0}; // +3 + -7
    vecs[12] = '{8'b0111_1111, 8'b1111_1111, 8'b0000_0000, 1'b0, 1'b1}; // +127 + -127

    // Reset state, checked before any clock edge.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    #2;
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one cycle of in_valid, result checked just after the next edge.
    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), 1'b1, vecs[i].s, vecs[i].ovf, vecs[i].zero);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00);
    end

    // Back-to-back acceptance on consecutive edges.
    @(negedge clk);
    drive(1'b1, vecs[0].a, vecs[0].b);
    @(posedge clk);
    #1;
    check_out("b2b0", 1'b1, vecs[0].s, vecs[0].ovf, vecs[0].zero);
    @(negedge clk);
    drive(1'b1, vecs[8].a, vecs[8].b);
    @(posedge clk);
    #1;
    check_out("b2b1", 1'b1, vecs[8].s, vecs[8].ovf, vecs[8].zero);

    // Idle for 3 cycles with different operands on the bus: outputs hold.
    @(negedge clk);
    drive(1'b0, 8'h11, 8'h22);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("idle%0d", i), 1'b0, vecs[8].s, vecs[8].ovf, vecs[8].zero);
    end

    // Asynchronous reset between edges while a result is valid.
    @(negedge clk);
    drive(1'b1, vecs[3].a, vecs[3].b);
    @(posedge clk);
    #1;
    check_out("pre_rst", 1'b1, vecs[3].s, vecs[3].ovf, vecs[3].zero);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    // In-flight operands under reset are discarded.
    drive(1'b1, vecs[8].a, vecs[8].b);
    @(posedge clk);
    #1;
    check_out("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // First edge after release accepts.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, vecs[1].a, vecs[1].b);
    @(posedge clk);
    #1;
    check_out("post_rst", 1'b1, vecs[1].s, vecs[1].ovf, vecs[1].zero);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_out("post_idle", 1'b0, vecs[1].s, vecs[1].ovf, vecs[1].zero);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_adder.md
SIGNED_ADDER -- requirements
Module: signed_adder

Interface
REQ-001 Parameter N, default 8: total word width (1 sign bit plus N-1 magnitude bits); N SHALL be at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  A and B are valid this cycle.
REQ-005 A  input  N  sign-magnitude operand: bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude.
REQ-006 B  input  N  sign-magnitude operand, same format as A.
REQ-007 S  output  N  registered sign-magnitude sum A+B.
REQ-008 out_valid  output  1  S, ovf and zero hold the result of an accepted operand pair.
REQ-009 ovf  output  1  result magnitude exceeded 2^(N-1)-1.
REQ-010 zero  output  1  result magnitude is 0.

Function
REQ-011 Operands SHALL be accepted on a rising clk edge when in_valid=1; no back-pressure, one pair accepted per cycle.
REQ-012 Latency SHALL be exactly 1 cycle: out_valid=1 in the cycle after acceptance, else 0.
REQ-013 S, ovf and zero SHALL hold their last value while out_valid=0.
REQ-014 Equal signs: magnitude = |A|+|B| over N-1 bits; sign = the common sign.
REQ-015 Equal signs with a carry out of bit N-2: ovf=1; S magnitude = the low N-1 bits (wraps); sign = the common sign.
REQ-016 Different signs: magnitude = larger magnitude minus smaller; sign = sign of the larger-magnitude operand; ovf=0.
REQ-017 Different signs with equal magnitudes: S = all zeros (+0).
REQ-018 A zero-magnitude result SHALL always be output with sign 0; negative zero is never produced.
REQ-019 Negative-zero inputs (sign 1, magnitude 0) SHALL be treated as +0.
REQ-020 zero=1 iff the S magnitude is 0, regardless of ovf.
REQ-021 Magnitude compare, add and subtract SHALL be combinational and unsigned; the datapath SHALL be registered only at the outputs.

Reset
REQ-022 While rst_n=0: S=0, ovf=0, zero=0 and out_valid=0, applied immediately without waiting for clk.
REQ-023 An operation in flight when reset asserts SHALL be discarded.
REQ-024 Release of rst_n SHALL be synchronised to clk by the integrator; first acceptance is possible on the first edge after release.

Structure
REQ-025 The default width constant (8) and a sign-magnitude word typedef SHALL live in a shared package, sm_pkg.
REQ-026 One sub-module, sm_mag_addsub, SHALL contain the combinational core.
REQ-027 sm_mag_addsub inputs: two magnitudes and two signs; outputs: result magnitude, sign and overflow.
REQ-028 signed_adder SHALL contain only the handshake and the output registers.

Verification (N=8; each row: in_valid=1 for one cycle, then check the outputs on the next cycle)
REQ-029 A=11000110 (-70), B=10011110 (-30) -> S=11100100 (-100), ovf=0, zero=0.
REQ-030 A=01101101 (+109), B=11001011 (-75) -> S=00100010 (+34), ovf=0.
REQ-031 A=10111000 (-56), B=00001101 (+13) -> S=10101011 (-43), ovf=0.
REQ-032 A=00010100 (+20), B=00101111 (+47) -> S=01000011 (+67), ovf=0.
REQ-033 Boundary cases, each checked separately:
- A=01111111, B=00000001 -> ovf=1, S=00000000.
- A=00101000, B=10101000 -> S=00000000, zero=1.
- A=10000000, B=10000000 -> S=00000000.
REQ-034 Assert rst_n=0 between clk edges while out_valid=1 -> all outputs 0 immediately.
REQ-035 in_valid held low for 3 cycles -> out_valid=0 and S unchanged throughout.
